// File: rtl/srl_array_e.sv
// Multi-bit addressable shift-register LUT with clock enable, asynchronous clear,
// fill tracking, selectable active clock edge and optional registered tap output.
module srl_array_e #(
   parameter int               WIDTH      = 8,
   parameter int               DEPTH      = 16,
   parameter int               AWIDTH     = 4,
   parameter logic [WIDTH-1:0] INIT_VALUE = {WIDTH{1'b0}},
   parameter int               NEG_CLK    = 0,
   parameter int               REG_OUT    = 0
) (
   input  logic              CLK,
   input  logic              CLR,
   input  logic              CE,
   input  logic [WIDTH-1:0]  D,
   input  logic [AWIDTH-1:0] A,
   output logic [WIDTH-1:0]  Q,
   output logic [WIDTH-1:0]  QLAST,
   output logic              VALID,
   output logic              FULL
);

   localparam logic [AWIDTH-1:0] LAST_TAP = AWIDTH'(DEPTH - 1);
   localparam logic [AWIDTH:0]   FILL_MAX = (AWIDTH + 1)'(DEPTH);
   localparam logic              CLK_INV  = (NEG_CLK != 0) ? 1'b1 : 1'b0;

   logic [WIDTH-1:0]  r_data [DEPTH];
   logic [WIDTH-1:0]  w_data_next [DEPTH];
   logic [AWIDTH:0]   r_fill;
   logic [AWIDTH:0]   w_fill_next;
   logic [AWIDTH-1:0] w_a_eff;
   logic              w_clk;

   // A constant inversion selects the falling edge without duplicating the state logic.
   assign w_clk = CLK ^ CLK_INV;

   if (DEPTH == (2 ** AWIDTH)) begin : g_no_clamp
      assign w_a_eff = A;
   end else begin : g_clamp
      assign w_a_eff = (A > LAST_TAP) ? LAST_TAP : A;
   end

   // Ternaries on CE so an unknown enable merges into X rather than silently holding.
   always_comb begin
      w_data_next[0] = CE ? D : r_data[0];
      for (int i = 1; i < DEPTH; i++) begin
         w_data_next[i] = CE ? r_data[i-1] : r_data[i];
      end
      w_fill_next = (CE && (r_fill != FILL_MAX)) ? (r_fill + {{AWIDTH{1'b0}}, 1'b1}) : r_fill;
   end

   always_ff @(posedge w_clk or posedge CLR) begin
      if (CLR) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_data[i] <= INIT_VALUE;
         end
         r_fill <= {(AWIDTH + 1){1'b0}};
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            r_data[i] <= w_data_next[i];
         end
         r_fill <= w_fill_next;
      end
   end

   assign QLAST = r_data[DEPTH-1];
   assign FULL  = (r_fill == FILL_MAX);

   if (REG_OUT != 0) begin : g_reg_out
      logic [WIDTH-1:0] r_q;
      logic             r_valid;

      // Registered tap samples post-shift contents so it matches the combinational view after the edge.
      always_ff @(posedge w_clk or posedge CLR) begin
         if (CLR) begin
            r_q     <= INIT_VALUE;
            r_valid <= 1'b0;
         end else begin
            r_q     <= w_data_next[w_a_eff];
            r_valid <= (w_fill_next > {1'b0, w_a_eff});
         end
      end

      assign Q     = r_q;
      assign VALID = r_valid;
   end else begin : g_comb_out
      assign Q     = r_data[w_a_eff];
      assign VALID = (r_fill > {1'b0, w_a_eff});
   end

endmodule
